// File: rtl/cnt4_ctrl_if.sv
// rtl/cnt4_ctrl_if.sv - control/status bundle between the counter controller and its user
interface cnt4_ctrl_if #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 4
);
    logic              ENB;
    logic [1:0]        MODE;
    logic [WIDTH-1:0]  D;
    logic [WIDTH-1:0]  Q;
    logic              S_OUT;
    logic [1:0]        STATE;
    logic [WRAP_W-1:0] WRAPS;

    modport master (
        output ENB, MODE, D,
        input  Q, S_OUT, STATE, WRAPS
    );

    modport slave (
        input  ENB, MODE, D,
        output Q, S_OUT, STATE, WRAPS
    );
endinterface

// File: rtl/cnt4_ctrl.sv
// rtl/cnt4_ctrl.sv - 4-bit counter sequencing controller with registered outputs and wrap tally
module cnt4_ctrl #(
    parameter int WIDTH  = 4,
    parameter int STEP   = 3,
    parameter int WRAP_W = 4
) (
    input  logic      CLK,
    input  logic      RESET_N,
    cnt4_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        LOAD = 2'b10
    } state_t;

    localparam logic [WIDTH:0]    ONE_EXT  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0]    STEP_EXT = (WIDTH+1)'(STEP);
    localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

    state_t            state_r, state_nxt;
    logic [WIDTH-1:0]  q_r, q_nxt;
    logic              s_r, s_nxt;
    logic [WRAP_W-1:0] wraps_r, wraps_nxt;

    // One extra bit on the sum exposes carry (up) or borrow (down) as the MSB.
    logic [WIDTH:0]    sum_ext;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= IDLE;
            q_r     <= '0;
            s_r     <= 1'b0;
            wraps_r <= '0;
        end else begin
            state_r <= state_nxt;
            q_r     <= q_nxt;
            s_r     <= s_nxt;
            wraps_r <= wraps_nxt;
        end
    end

    always_comb begin
        state_nxt = state_r;
        q_nxt     = q_r;
        s_nxt     = 1'b0;
        wraps_nxt = wraps_r;
        sum_ext   = {1'b0, q_r};

        if (!bus.ENB) begin
            state_nxt = IDLE;
        end else begin
            case (bus.MODE)
                2'b00: begin
                    state_nxt = RUN;
                    sum_ext   = {1'b0, q_r} + ONE_EXT;
                    q_nxt     = sum_ext[WIDTH-1:0];
                    s_nxt     = sum_ext[WIDTH];
                end
                2'b01: begin
                    state_nxt = RUN;
                    sum_ext   = {1'b0, q_r} - ONE_EXT;
                    q_nxt     = sum_ext[WIDTH-1:0];
                    s_nxt     = sum_ext[WIDTH];
                end
                2'b10: begin
                    state_nxt = RUN;
                    sum_ext   = {1'b0, q_r} + STEP_EXT;
                    q_nxt     = sum_ext[WIDTH-1:0];
                    s_nxt     = sum_ext[WIDTH];
                end
                2'b11: begin
                    // Load overrides any carry this edge would otherwise produce.
                    state_nxt = LOAD;
                    q_nxt     = bus.D;
                    wraps_nxt = '0;
                end
                default: begin
                    state_nxt = state_r;
                end
            endcase

            if (s_nxt && (wraps_r != WRAP_MAX)) begin
                wraps_nxt = wraps_r + 1'b1;
            end
        end
    end

    assign bus.Q     = q_r;
    assign bus.S_OUT = s_r;
    assign bus.STATE = state_r;
    assign bus.WRAPS = wraps_r;

endmodule

// File: tb/tb_cnt4_ctrl.sv
// tb/tb_cnt4_ctrl.sv - randomized and directed bench for cnt4_ctrl against an arithmetic reference model
module tb_cnt4_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    cnt4_ctrl_if #(.WIDTH(4), .WRAP_W(4)) bus();

    cnt4_ctrl #(.WIDTH(4), .STEP(3), .WRAP_W(4)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    int m_q, m_s, m_state, m_wraps;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_s = 0; m_state = 0; m_wraps = 0;
    endtask

    task automatic model_step(input int enb, input int mode, input int d);
        int delta, tmp;
        if (enb == 0) begin
            m_state = 0;
            m_s     = 0;
        end else if (mode == 3) begin
            m_state = 2;
            m_q     = d;
            m_s     = 0;
            m_wraps = 0;
        end else begin
            delta   = (mode == 0) ? 1 : (mode == 1) ? -1 : 3;
            tmp     = m_q + delta;
            m_s     = (tmp < 0 || tmp > 15) ? 1 : 0;
            m_q     = (tmp + 16) % 16;
            m_state = 1;
            if (m_s == 1 && m_wraps < 15) m_wraps++;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},     int'(bus.Q),     m_q);
        check({tag, ".s"},     int'(bus.S_OUT), m_s);
        check({tag, ".state"}, int'(bus.STATE), m_state);
        check({tag, ".wraps"}, int'(bus.WRAPS), m_wraps);
    endtask

    // Called at a negedge: drive, take one rising edge, check 1 ns later, return to negedge.
    task automatic cycle(input string tag, input int enb, input int mode, input int d);
        bus.ENB  = enb[0];
        bus.MODE = mode[1:0];
        bus.D    = d[3:0];
        @(posedge clk);
        model_step(enb, mode, d);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.ENB  = 1'b0;
        bus.MODE = 2'b00;
        bus.D    = 4'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) cycle("count9", 1, 0, 0);
        check("count9.const", int'(bus.Q), 9);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        check_all("reset_hold");
        rst_n = 1'b1;

        cycle("upwrap.load", 1, 3, 14);
        for (int i = 0; i < 3; i++) cycle("upwrap", 1, 0, 0);
        check("upwrap.q_const", int'(bus.Q), 1);
        check("upwrap.wraps_const", int'(bus.WRAPS), 1);

        cycle("down.load", 1, 3, 1);
        for (int i = 0; i < 3; i++) cycle("down", 1, 1, 0);
        check("down.q_const", int'(bus.Q), 14);

        cycle("step.load", 1, 3, 12);
        for (int i = 0; i < 3; i++) cycle("step", 1, 2, 0);
        check("step.q_const", int'(bus.Q), 5);
        cycle("step13.load", 1, 3, 13);
        cycle("step13", 1, 2, 0);
        check("step13.q_const", int'(bus.Q), 0);
        check("step13.s_const", int'(bus.S_OUT), 1);

        cycle("gap.load", 1, 3, 5);
        cycle("gap", 0, 2, 9);
        cycle("gap", 0, 0, 3);
        check("gap.q_const", int'(bus.Q), 5);
        cycle("gap.resume", 1, 1, 0);
        check("gap.resume_const", int'(bus.Q), 4);

        cycle("sat.load", 1, 3, 0);
        for (int i = 0; i < 320; i++) cycle("sat", 1, 0, 0);
        check("sat.wraps_const", int'(bus.WRAPS), 15);
        cycle("sat.clear", 1, 3, 7);
        check("sat.clear_q", int'(bus.Q), 7);
        check("sat.clear_wraps", int'(bus.WRAPS), 0);
        check("sat.clear_state", int'(bus.STATE), 2);

        for (int i = 0; i < 600; i++) begin
            int enb, mode, d;
            enb  = ($urandom_range(0, 7) != 0) ? 1 : 0;
            mode = int'($urandom_range(0, 3));
            if (mode == 3 && $urandom_range(0, 3) != 0) mode = int'($urandom_range(0, 2));
            d    = int'($urandom_range(0, 15));
            cycle("rand", enb, mode, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cnt4_ctrl.md
Name: cnt4_ctrl

Overview:
Sequencing controller for the 4-bit counter output register bank (state bits Q[3:0] plus rollover flag S_OUT). It computes next-state values from mode and enable inputs, holds them in its own flops, and reports controller state. It also keeps a saturating rollover tally for the action logic. All outputs are registered, so downstream logic sees clean edges one cycle after a decision.

Parameters:
WIDTH, 4, counter width (Q, D); the design is verified at 4 only.
STEP, 3, increment used in MODE=10.
WRAP_W, 4, width of the rollover tally WRAPS.

Ports:
CLK  input  1  rising-edge clock
RESET_N  input  1  asynchronous, active-low reset; deassertion synchronous to CLK
ENB  input  1  counter enable; 0 = hold
MODE  input  2  00 up-by-1, 01 down-by-1, 10 up-by-STEP, 11 parallel load
D  input  WIDTH  load value, sampled when ENB=1 and MODE=11
Q  output  WIDTH  registered count
S_OUT  output  1  registered rollover/borrow flag, one cycle wide
STATE  output  2  registered controller state: 00 IDLE, 01 RUN, 10 LOAD
WRAPS  output  WRAP_W  saturating count of S_OUT pulses since the last load or reset

Behaviour:
- Reset (RESET_N=0, asynchronous): Q=0, S_OUT=0, STATE=IDLE(00), WRAPS=0. All outputs hold these values while reset is low, including when reset hits mid-count.
- Timing: every output updates on the rising CLK edge from inputs sampled at that edge. Latency from input to output is 1 cycle. There is no combinational path from inputs to outputs.
- FSM, evaluated every edge:
  - ENB=0: go to IDLE. Q holds, S_OUT=0, WRAPS holds.
  - ENB=1, MODE=11: go to LOAD. Q=D, S_OUT=0, WRAPS=0.
  - ENB=1, MODE in {00,01,10}: go to RUN and apply the arithmetic below.
  - Any state can reach any state in one edge. No state requires a minimum dwell time.
- Arithmetic (modulo 2^WIDTH, carry/borrow out drives S_OUT):
  - MODE=00: Q=Q+1. S_OUT=1 only when the old Q=15 (result 0).
  - MODE=01: Q=Q-1. S_OUT=1 only when the old Q=0 (result 15).
  - MODE=10: Q=Q+STEP. S_OUT=1 when the old Q >= 16-STEP (13..15 give 0..2).
  - S_OUT is 0 on every edge that has no carry or borrow. Consecutive wrapping edges give S_OUT=1 on each of them.
- WRAPS:
  - Increments on every edge that sets S_OUT=1.
  - Saturates at 2^WRAP_W-1 and never wraps to 0.
  - Cleared only by reset or LOAD.
- Mode change while in RUN: the new mode applies on the very next edge. There is no pipeline flush and no bubble.
- Load while a wrap is pending: load wins. S_OUT=0 and WRAPS=0 on that edge.
- Unknown or X on MODE while ENB=1 is a verification error. The implementation treats the default branch as hold.

Test Plan:
- Reset mid-count: run MODE=00 to Q=9, pull RESET_N low between edges -> Q=0, S_OUT=0, STATE=00, WRAPS=0 immediately, without waiting for CLK.
- Up wrap: load D=14, then 3 edges at MODE=00 -> Q=15,0,1. S_OUT=0,1,0. WRAPS=1. STATE=01.
- Down borrow: load D=1, then 3 edges at MODE=01 -> Q=0,15,14. S_OUT=0,1,0. WRAPS=1.
- Step-3 carry: load D=12, then 3 edges at MODE=10 -> Q=15,2,5. S_OUT=0,1,0. From Q=13, one edge gives Q=0 with S_OUT=1.
- Enable gap and mode switch: at Q=5 set ENB=0 for 2 edges -> Q=5, STATE=00, S_OUT=0. Then ENB=1 with MODE=01 on the first edge -> Q=4, STATE=01.
- WRAPS saturation and clear: run MODE=00 for 20 full periods (320 edges) -> WRAPS=15 and stays 15. Then MODE=11 with D=7 -> Q=7, WRAPS=0, S_OUT=0, STATE=10.
